// File: rtl/sm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sm_mem_arbiter
//
// Shares one single-port synchronous memory (1-cycle read latency) between
// two masters. Master 0 is the CPU instruction-fetch port and master 1 is the
// loader/debug port. Grants are combinational from the requests and the
// registered arbitration state. Read data is routed back one cycle after the
// grant to whichever master issued the read.
//
// Arbitration (default build): round-robin with a burst limit. Under
// contention the last owner keeps the memory until it has taken MAX_BURST
// consecutive grants, and then the other master wins. A lone requester is
// always granted.
//
// Build option SM_ARB_FIXED_PRIO_EN: when defined, master 0 always wins
// contention and master 1 is granted only while m0_req is low. The burst
// counter does not exist in that build. The port list is the same.
//
// Parameters
//   AW         word-address width
//   DW         data width
//   MAX_BURST  max consecutive grants to one master under contention (>=1)
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   mX_req/we/addr/wdata       master X request, write enable, address, data
//   mX_gnt                     master X request accepted this cycle
//   mX_rvalid/rdata            master X read return (rdata is 0 when not valid)
//   mem_en/we/addr/wdata       memory strobe and granted master's command
//   mem_rdata                  memory read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sm_mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic gnt0;
    logic gnt1;

`ifdef SM_ARB_FIXED_PRIO_EN

    always_comb begin
        gnt0 = rst_n & m0_req;
        gnt1 = rst_n & m1_req & ~m0_req;
    end

`else

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             lastOwner;
    logic [CNT_W-1:0] burstCnt;
    logic             ownerKeeps;
    logic             winner;

    // A zero count means no burst is in progress (only right after reset).
    // The reset value of lastOwner (1) then hands the first contention to m0.
    always_comb begin
        ownerKeeps = (burstCnt != '0) && (burstCnt < CNT_W'(MAX_BURST));
        winner     = ownerKeeps ? lastOwner : ~lastOwner;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                gnt0 = ~winner;
                gnt1 = winner;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lastOwner <= 1'b1;
            burstCnt  <= '0;
        end else if (gnt0 || gnt1) begin
            lastOwner <= gnt1;
            if (gnt1 != lastOwner) begin
                burstCnt <= CNT_W'(1);
            end else if (burstCnt < CNT_W'(MAX_BURST)) begin
                burstCnt <= burstCnt + CNT_W'(1);
            end
        end
    end

`endif

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (gnt1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // ---- stage p1: read return, one cycle after the accepted read ----
    logic readPend_p1;
    logic readId_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            readPend_p1 <= 1'b0;
        end else begin
            readPend_p1 <= mem_en & ~mem_we;
        end
        // The id only matters while readPend_p1 is set, so it needs no reset.
        readId_p1 <= gnt1;
    end

    always_comb begin
        m0_rvalid = readPend_p1 & ~readId_p1;
        m1_rvalid = readPend_p1 & readId_p1;
        m0_rdata  = m0_rvalid ? mem_rdata : '0;
        m1_rdata  = m1_rvalid ? mem_rdata : '0;
    end

endmodule
